// File: rtl/id_ex_registro_pkg.sv
// rtl/id_ex_registro_pkg.sv - shared encodings and default widths for the ID/EX pipeline register
package id_ex_registro_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_REG_DEF  = 5;
  localparam int NB_CNT_DEF  = 16;

  // Fourteen single control bits plus four 2-bit control fields
  localparam int NB_CTRL = 22;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_IMM   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_RSVD  = 2'b11
  } ext_mode_e;

  typedef enum logic [1:0] {
    TAM_BYTE = 2'b00,
    TAM_HALF = 2'b01,
    TAM_WORD = 2'b11,
    TAM_RSVD = 2'b10
  } tamano_filtro_e;

endpackage

// File: rtl/id_ex_registro_bubble_counter.sv
// rtl/id_ex_registro_bubble_counter.sv - saturating event counter for pipeline bubbles
module id_ex_registro_bubble_counter #(
  parameter int NB_CNT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  output logic [NB_CNT-1:0] o_cnt
);

  logic [NB_CNT-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {NB_CNT{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/id_ex_registro.sv
// rtl/id_ex_registro.sv - ID/EX pipeline register with step gating, flush and bubble tagging
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_registro
  import id_ex_registro_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_CNT  = NB_CNT_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_Step,
  input  logic               i_Flush,
  input  logic               i_Riesgo,
  input  logic               i_RegDst,
  input  logic               i_Jump,
  input  logic               i_JAL,
  input  logic               i_Branch,
  input  logic               i_NBranch,
  input  logic               i_MemRead,
  input  logic               i_MemToReg,
  input  logic               i_MemWrite,
  input  logic               i_ALUSrc,
  input  logic               i_RegWrite,
  input  logic               i_ZeroExtend,
  input  logic               i_LUI,
  input  logic               i_JALR,
  input  logic               i_HALT,
  input  logic [1:0]         i_ALUOp,
  input  logic [1:0]         i_ExtensionMode,
  input  logic [1:0]         i_TamanoFiltro,
  input  logic [1:0]         i_TamanoFiltroL,
  input  logic [NB_DATA-1:0] i_PC4,
  input  logic [NB_DATA-1:0] i_DatoA,
  input  logic [NB_DATA-1:0] i_DatoB,
  input  logic [NB_DATA-1:0] i_Extension,
  input  logic [NB_REG-1:0]  i_Rs,
  input  logic [NB_REG-1:0]  i_Rt,
  input  logic [NB_REG-1:0]  i_Rd,
  output logic               o_RegDst,
  output logic               o_Jump,
  output logic               o_JAL,
  output logic               o_Branch,
  output logic               o_NBranch,
  output logic               o_MemRead,
  output logic               o_MemToReg,
  output logic               o_MemWrite,
  output logic               o_ALUSrc,
  output logic               o_RegWrite,
  output logic               o_ZeroExtend,
  output logic               o_LUI,
  output logic               o_JALR,
  output logic               o_HALT,
  output logic [1:0]         o_ALUOp,
  output logic [1:0]         o_ExtensionMode,
  output logic [1:0]         o_TamanoFiltro,
  output logic [1:0]         o_TamanoFiltroL,
  output logic [NB_DATA-1:0] o_PC4,
  output logic [NB_DATA-1:0] o_DatoA,
  output logic [NB_DATA-1:0] o_DatoB,
  output logic [NB_DATA-1:0] o_Extension,
  output logic [NB_REG-1:0]  o_Rs,
  output logic [NB_REG-1:0]  o_Rt,
  output logic [NB_REG-1:0]  o_Rd,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [NB_CNT-1:0]  o_BubbleCnt,
`endif
  output logic               o_Valid
);

  logic [NB_CTRL-1:0] w_ctrl_d;
  logic [NB_CTRL-1:0] r_ctrl;
  logic [NB_DATA-1:0] r_PC4;
  logic [NB_DATA-1:0] r_DatoA;
  logic [NB_DATA-1:0] r_DatoB;
  logic [NB_DATA-1:0] r_Extension;
  logic [NB_REG-1:0]  r_Rs;
  logic [NB_REG-1:0]  r_Rt;
  logic [NB_REG-1:0]  r_Rd;
  logic               r_Valid;

  assign w_ctrl_d = {i_RegDst, i_Jump, i_JAL, i_Branch, i_NBranch, i_MemRead,
                     i_MemToReg, i_MemWrite, i_ALUSrc, i_RegWrite, i_ZeroExtend,
                     i_LUI, i_JALR, i_HALT, i_ALUOp, i_ExtensionMode,
                     i_TamanoFiltro, i_TamanoFiltroL};

  // HALT travels with the rest of the control bundle: only flush or reset clear it
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ctrl      <= '0;
      r_PC4       <= '0;
      r_DatoA     <= '0;
      r_DatoB     <= '0;
      r_Extension <= '0;
      r_Rs        <= '0;
      r_Rt        <= '0;
      r_Rd        <= '0;
      r_Valid     <= 1'b0;
    end else if (i_Step) begin
      if (i_Flush) begin
        r_ctrl      <= '0;
        r_PC4       <= '0;
        r_DatoA     <= '0;
        r_DatoB     <= '0;
        r_Extension <= '0;
        r_Rs        <= '0;
        r_Rt        <= '0;
        r_Rd        <= '0;
        r_Valid     <= 1'b0;
      end else begin
        r_ctrl      <= w_ctrl_d;
        r_PC4       <= i_PC4;
        r_DatoA     <= i_DatoA;
        r_DatoB     <= i_DatoB;
        r_Extension <= i_Extension;
        r_Rs        <= i_Rs;
        r_Rt        <= i_Rt;
        r_Rd        <= i_Rd;
        r_Valid     <= ~i_Riesgo;
      end
    end
  end

  assign {o_RegDst, o_Jump, o_JAL, o_Branch, o_NBranch, o_MemRead,
          o_MemToReg, o_MemWrite, o_ALUSrc, o_RegWrite, o_ZeroExtend,
          o_LUI, o_JALR, o_HALT, o_ALUOp, o_ExtensionMode,
          o_TamanoFiltro, o_TamanoFiltroL} = r_ctrl;

  assign o_PC4       = r_PC4;
  assign o_DatoA     = r_DatoA;
  assign o_DatoB     = r_DatoB;
  assign o_Extension = r_Extension;
  assign o_Rs        = r_Rs;
  assign o_Rt        = r_Rt;
  assign o_Rd        = r_Rd;
  assign o_Valid     = r_Valid;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic w_bubble_load;

  // A bubble is any stepped edge whose loaded entry is not valid
  assign w_bubble_load = i_Step & (i_Flush | i_Riesgo);

  id_ex_registro_bubble_counter #(
    .NB_CNT(NB_CNT)
  ) u_bubble_counter (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_en   (w_bubble_load),
    .o_cnt  (o_BubbleCnt)
  );
`endif

endmodule

// File: tb/tb_id_ex_registro.sv
// tb/tb_id_ex_registro.sv - self-checking bench for id_ex_registro (covers ID_EX_BUBBLE_CNT_EN when defined)
module tb_id_ex_registro;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int NB_CNT  = 4;
  localparam int CNT_MAX = (1 << NB_CNT) - 1;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_Step;
  logic              i_Flush;
  logic              i_Riesgo;
  logic [21:0]       c_in;
  logic [NB_DATA-1:0] pc4_in, a_in, b_in, ext_in;
  logic [NB_REG-1:0]  rs_in, rt_in, rd_in;

  wire  [21:0]        c_out;
  wire  [NB_DATA-1:0] pc4_out, a_out, b_out, ext_out;
  wire  [NB_REG-1:0]  rs_out, rt_out, rd_out;
  wire                valid_out;
`ifdef ID_EX_BUBBLE_CNT_EN
  wire  [NB_CNT-1:0]  cnt_out;
`endif

  // Reference state: what EX should see after the last edge
  logic [21:0]        exp_c;
  logic [NB_DATA-1:0] exp_pc4, exp_a, exp_b, exp_ext;
  logic [NB_REG-1:0]  exp_rs, exp_rt, exp_rd;
  logic               exp_valid;
  int                 exp_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  id_ex_registro #(
    .NB_DATA(NB_DATA),
    .NB_REG (NB_REG),
    .NB_CNT (NB_CNT)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_Step         (i_Step),
    .i_Flush        (i_Flush),
    .i_Riesgo       (i_Riesgo),
    .i_RegDst       (c_in[21]),
    .i_Jump         (c_in[20]),
    .i_JAL          (c_in[19]),
    .i_Branch       (c_in[18]),
    .i_NBranch      (c_in[17]),
    .i_MemRead      (c_in[16]),
    .i_MemToReg     (c_in[15]),
    .i_MemWrite     (c_in[14]),
    .i_ALUSrc       (c_in[13]),
    .i_RegWrite     (c_in[12]),
    .i_ZeroExtend   (c_in[11]),
    .i_LUI          (c_in[10]),
    .i_JALR         (c_in[9]),
    .i_HALT         (c_in[8]),
    .i_ALUOp        (c_in[7:6]),
    .i_ExtensionMode(c_in[5:4]),
    .i_TamanoFiltro (c_in[3:2]),
    .i_TamanoFiltroL(c_in[1:0]),
    .i_PC4          (pc4_in),
    .i_DatoA        (a_in),
    .i_DatoB        (b_in),
    .i_Extension    (ext_in),
    .i_Rs           (rs_in),
    .i_Rt           (rt_in),
    .i_Rd           (rd_in),
    .o_RegDst       (c_out[21]),
    .o_Jump         (c_out[20]),
    .o_JAL          (c_out[19]),
    .o_Branch       (c_out[18]),
    .o_NBranch      (c_out[17]),
    .o_MemRead      (c_out[16]),
    .o_MemToReg     (c_out[15]),
    .o_MemWrite     (c_out[14]),
    .o_ALUSrc       (c_out[13]),
    .o_RegWrite     (c_out[12]),
    .o_ZeroExtend   (c_out[11]),
    .o_LUI          (c_out[10]),
    .o_JALR         (c_out[9]),
    .o_HALT         (c_out[8]),
    .o_ALUOp        (c_out[7:6]),
    .o_ExtensionMode(c_out[5:4]),
    .o_TamanoFiltro (c_out[3:2]),
    .o_TamanoFiltroL(c_out[1:0]),
    .o_PC4          (pc4_out),
    .o_DatoA        (a_out),
    .o_DatoB        (b_out),
    .o_Extension    (ext_out),
    .o_Rs           (rs_out),
    .o_Rt           (rt_out),
    .o_Rd           (rd_out),
`ifdef ID_EX_BUBBLE_CNT_EN
    .o_BubbleCnt    (cnt_out),
`endif
    .o_Valid        (valid_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_c = '0; exp_pc4 = '0; exp_a = '0; exp_b = '0; exp_ext = '0;
    exp_rs = '0; exp_rt = '0; exp_rd = '0; exp_valid = 1'b0; exp_cnt = 0;
  endtask

  // Behavioural rule set: hold when not stepping, flush zeroes everything, otherwise copy
  task automatic model_edge();
    if (i_Step) begin
      if (i_Flush) begin
        exp_c = '0; exp_pc4 = '0; exp_a = '0; exp_b = '0; exp_ext = '0;
        exp_rs = '0; exp_rt = '0; exp_rd = '0; exp_valid = 1'b0;
      end else begin
        exp_c = c_in; exp_pc4 = pc4_in; exp_a = a_in; exp_b = b_in; exp_ext = ext_in;
        exp_rs = rs_in; exp_rt = rt_in; exp_rd = rd_in; exp_valid = !i_Riesgo;
      end
      if (!exp_valid && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ctrl"}, 64'(c_out), 64'(exp_c));
    chk({tag, ".pc4"},  64'(pc4_out), 64'(exp_pc4));
    chk({tag, ".a"},    64'(a_out), 64'(exp_a));
    chk({tag, ".b"},    64'(b_out), 64'(exp_b));
    chk({tag, ".ext"},  64'(ext_out), 64'(exp_ext));
    chk({tag, ".regs"}, 64'({rs_out, rt_out, rd_out}), 64'({exp_rs, exp_rt, exp_rd}));
    chk({tag, ".valid"}, 64'(valid_out), 64'(exp_valid));
`ifdef ID_EX_BUBBLE_CNT_EN
    chk({tag, ".cnt"}, 64'(cnt_out), 64'(exp_cnt));
`endif
  endtask

  task automatic rand_in();
    c_in   = 22'($urandom);
    pc4_in = $urandom;
    a_in   = $urandom;
    b_in   = $urandom;
    ext_in = $urandom;
    rs_in  = 5'($urandom);
    rt_in  = 5'($urandom);
    rd_in  = 5'($urandom);
  endtask

  task automatic tick(input string tag);
    @(posedge i_clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    i_reset = 1'b1; i_Step = 1'b0; i_Flush = 1'b0; i_Riesgo = 1'b0;
    c_in = '0; pc4_in = '0; a_in = '0; b_in = '0; ext_in = '0;
    rs_in = '0; rt_in = '0; rd_in = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check_all("reset");
    @(negedge i_clk);
    i_reset = 1'b0;

    // Normal load
    rand_in();
    i_Step = 1'b1; i_Flush = 1'b0; i_Riesgo = 1'b0;
    a_in = 32'hDEADBEEF; c_in[7:6] = 2'b10; rd_in = 5'd7;
    tick("load");
    chk("load.DatoA", 64'(a_out), 64'hDEADBEEF);
    chk("load.ALUOp", 64'(c_out[7:6]), 64'h2);
    chk("load.Rd", 64'(rd_out), 64'd7);
    chk("load.Valid", 64'(valid_out), 64'd1);

    // Hold with flush asserted: nothing moves
    for (int k = 0; k < 3; k++) begin
      rand_in();
      i_Step = 1'b0; i_Flush = 1'b1; i_Riesgo = 1'($urandom);
      tick("hold");
      chk("hold.DatoA", 64'(a_out), 64'hDEADBEEF);
      chk("hold.Valid", 64'(valid_out), 64'd1);
    end

    // Load-use hazard: data loads, entry tagged as bubble
    i_Step = 1'b1; i_Flush = 1'b0; i_Riesgo = 1'b1;
    c_in = '0; b_in = 32'h5;
    tick("hazard");
    chk("hazard.DatoB", 64'(b_out), 64'h5);
    chk("hazard.RegWrite", 64'(c_out[12]), 64'd0);
    chk("hazard.Valid", 64'(valid_out), 64'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("hazard.BubbleCnt", 64'(cnt_out), 64'd1);
`endif

    // Flush beats hazard and clears HALT
    rand_in();
    i_Flush = 1'b1; i_Riesgo = 1'b1; c_in[8] = 1'b1; pc4_in = 32'h20;
    tick("flush");
    chk("flush.HALT", 64'(c_out[8]), 64'd0);
    chk("flush.PC4", 64'(pc4_out), 64'd0);
    chk("flush.Valid", 64'(valid_out), 64'd0);

    // Random mix of step/flush/hazard
    for (int k = 0; k < 300; k++) begin
      rand_in();
      i_Step   = ($urandom % 4) != 0;
      i_Flush  = ($urandom % 5) == 0;
      i_Riesgo = ($urandom % 4) == 0;
      tick("rand");
    end

    // Long flush run drives the counter into saturation
    i_Step = 1'b1; i_Flush = 1'b1; i_Riesgo = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rand_in();
      tick("sat");
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("sat.BubbleCnt", 64'(cnt_out), 64'(CNT_MAX));
`endif

    // Asynchronous reset between edges
    rand_in();
    i_Flush = 1'b0; pc4_in = 32'h10; c_in[12] = 1'b1;
    tick("preRst");
    chk("preRst.PC4", 64'(pc4_out), 64'h10);
    #3;
    i_reset = 1'b1;
    #1;
    model_reset();
    check_all("asyncRst");
    chk("asyncRst.RegWrite", 64'(c_out[12]), 64'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    rand_in();
    i_Step = 1'b1; i_Flush = 1'b0; i_Riesgo = 1'b0;
    tick("postRst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
